seq_shifter: RTL

Iterative multi-cycle shift unit for the MIC-1 datapath. It complements the single-cycle combinational shifter by providing the opposite shift directions: logical right and logical left by a variable amount, plus rotate-right. It shifts one bit position per clock under a start/busy/done handshake. It sits beside the ALU/shifter stage and is used by microcode sequences that need variable-distance shifts the fixed SLL8/SRA1 path cannot perform.

---
 rtl/seq_shifter.sv | 79 +++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Iterative shift unit: SRL / SLL / ROR by a variable distance, one bit per clock,
// under a start/busy/done handshake. Result only updates on the edge entering DONE.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       SET,
  input  logic [AW-1:0]    Amount,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] w;
  } work_t;

  state_t           state, state_nxt;
  work_t            work;
  logic             accept, bypass, last;
  logic [WIDTH-1:0] shifted;

  // DONE accepts like IDLE so back-to-back requests skip the idle cycle
  assign accept = (state != SHIFT) && Start;
  assign bypass = (SET == 2'b00) || (Amount == '0);
  assign last   = (work.cnt == AW'(1));

  always_comb begin
    shifted = work.w;
    case (work.op)
      2'b01:   shifted = {1'b0, work.w[WIDTH-1:1]};
      2'b10:   shifted = {work.w[WIDTH-2:0], 1'b0};
      2'b11:   shifted = {work.w[0], work.w[WIDTH-1:1]};
      default: shifted = work.w;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = !Start ? IDLE : (bypass ? DONE : SHIFT);
      SHIFT:      state_nxt = last ? DONE : SHIFT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work   <= '0;
      Result <= '0;
    end else if (accept) begin
      work.w   <= Data_in;
      work.cnt <= Amount;
      work.op  <= SET;
      if (bypass) Result <= Data_in;
    end else if (state == SHIFT) begin
      work.w   <= shifted;
      work.cnt <= work.cnt - AW'(1);
      if (last) Result <= shifted;
    end
  end

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

endmodule
